// File: rtl/data_ram_pkg.sv
// rtl/data_ram_pkg.sv - shared encodings and lane helpers for the data RAM controller
package data_ram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Byte lanes touched by an access of the given size at the given offset
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << off;
            SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Reserved size or an offset not aligned to the access size
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        misaligned = (size == SZ_RSVD)
                   || (size == SZ_HALF && off[0])
                   || (size == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/data_ram_lane_fmt.sv
// rtl/data_ram_lane_fmt.sv - picks the addressed byte/half from a word and extends it
module data_ram_lane_fmt
    import data_ram_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = word_i[{off_i, 3'b000} +: 8];
    assign half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

    // Extension bit is the loaded value's MSB unless a zero-extending load
    always_comb begin
        data_o = '0;
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
            SZ_HALF: data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
            SZ_WORD: data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - byte-addressed data RAM with req/ready accept and latency-timed valid
module data_ram_ctrl
    import data_ram_pkg::*;
#(
    parameter int n   = 7,
    parameter int m   = 32,
    parameter int LAT = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         req_i,
    input  logic         we_i,
    input  logic [1:0]   size_i,
    input  logic         unsigned_i,
    input  logic [n-1:0] addr_i,
    input  logic [m-1:0] data_in_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [m-1:0] data_out_o,
    output logic         addr_err_o
);

    localparam int DEPTH = 2 ** (n - 2);
    // Remaining WAIT cycles after entry; only meaningful when LAT > 1
    localparam logic [1:0] WAIT_INIT = 2'((LAT > 1) ? LAT - 2 : 0);

    if (m != 32) begin : g_bad_width
        $error("data_ram_ctrl: m must be 32");
    end
    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("data_ram_ctrl: LAT must be 1..4");
    end

    logic [31:0] mem_q [DEPTH];

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;
    logic [1:0]  snap_size_q, snap_size_d;
    logic [1:0]  snap_off_q, snap_off_d;
    logic        snap_uns_q, snap_uns_d;
    logic [31:0] data_out_q, data_out_d;
    logic        addr_err_q, addr_err_d;

    logic [n-3:0] word_idx;
    logic [1:0]   byte_off;
    logic         req_err;
    logic         accept;
    logic         do_write;
    logic [3:0]   wr_mask;
    logic [31:0]  wr_data;
    logic [31:0]  fmt_word;
    logic [1:0]   fmt_size;
    logic [1:0]   fmt_off;
    logic         fmt_uns;
    logic [31:0]  fmt_data;

    assign word_idx = addr_i[n-1:2];
    assign byte_off = addr_i[1:0];
    assign req_err  = misaligned(size_i, byte_off);
    assign accept   = (state_q == S_IDLE) && req_i;
    assign do_write = accept && we_i && !req_err;
    assign wr_mask  = lane_mask(size_i, byte_off);

    // Narrow store data is replicated so every lane sees its own copy; the mask picks
    always_comb begin
        wr_data = data_in_i;
        case (size_i)
            SZ_BYTE: wr_data = {4{data_in_i[7:0]}};
            SZ_HALF: wr_data = {2{data_in_i[15:0]}};
            default: wr_data = data_in_i;
        endcase
    end

    // LAT=1 loads format the live array word; longer latencies format the snapshot
    always_comb begin
        fmt_word = snap_q;
        fmt_size = snap_size_q;
        fmt_off  = snap_off_q;
        fmt_uns  = snap_uns_q;
        if (state_q == S_IDLE) begin
            fmt_word = mem_q[word_idx];
            fmt_size = size_i;
            fmt_off  = byte_off;
            fmt_uns  = unsigned_i;
        end
    end

    data_ram_lane_fmt u_lane_fmt (
        .word_i     (fmt_word),
        .size_i     (fmt_size),
        .off_i      (fmt_off),
        .unsigned_i (fmt_uns),
        .data_o     (fmt_data)
    );

    // Next-state and response data; outputs default to zero outside the RESP cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        snap_size_d = snap_size_q;
        snap_off_d  = snap_off_q;
        snap_uns_d  = snap_uns_q;
        data_out_d  = '0;
        addr_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    if (req_err) begin
                        state_d    = S_RESP;
                        addr_err_d = 1'b1;
                    end else if (we_i) begin
                        state_d = S_RESP;
                    end else if (LAT == 1) begin
                        state_d    = S_RESP;
                        data_out_d = fmt_data;
                    end else begin
                        state_d     = S_WAIT;
                        cnt_d       = WAIT_INIT;
                        snap_d      = mem_q[word_idx];
                        snap_size_d = size_i;
                        snap_off_d  = byte_off;
                        snap_uns_d  = unsigned_i;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d    = S_RESP;
                    data_out_d = fmt_data;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers; reset drops any in-flight request
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            snap_q      <= '0;
            snap_size_q <= '0;
            snap_off_q  <= '0;
            snap_uns_q  <= 1'b0;
            data_out_q  <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            snap_size_q <= snap_size_d;
            snap_off_q  <= snap_off_d;
            snap_uns_q  <= snap_uns_d;
            data_out_q  <= data_out_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Array: cleared on reset, lane-masked store at the accept edge
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign ready_o    = (state_q == S_IDLE);
    assign valid_o    = (state_q == S_RESP);
    assign data_out_o = data_out_q;
    assign addr_err_o = addr_err_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb/tb_data_ram_ctrl.sv - randomized and directed bench for data_ram_ctrl at LAT 1..4
module tb_data_ram_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req   [1:4];
    logic        we    [1:4];
    logic [1:0]  size  [1:4];
    logic        uns   [1:4];
    logic [6:0]  addr  [1:4];
    logic [31:0] din   [1:4];
    logic        ready [1:4];
    logic        valid [1:4];
    logic [31:0] dout  [1:4];
    logic        aerr  [1:4];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mem_m [1:4][0:127];

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        data_ram_ctrl #(.n(7), .m(32), .LAT(g)) u_dut (
            .clk_i      (clk),
            .reset_i    (rst),
            .req_i      (req[g]),
            .we_i       (we[g]),
            .size_i     (size[g]),
            .unsigned_i (uns[g]),
            .addr_i     (addr[g]),
            .data_in_i  (din[g]),
            .ready_o    (ready[g]),
            .valid_o    (valid[g]),
            .data_out_o (dout[g]),
            .addr_err_o (aerr[g])
        );
    end

    function automatic void ref_clear();
        for (int d = 1; d <= 4; d++)
            for (int a = 0; a < 128; a++) mem_m[d][a] = 8'h00;
    endfunction

    function automatic logic ref_err(input logic [1:0] sz, input int a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // Expected {latency, data, err, clean-after} for one op; applies stores to the model
    function automatic logic [41:0] exp_op(input int d, input logic w, input logic [1:0] sz,
                                           input logic u, input int a, input logic [31:0] wd);
        logic        e;
        logic [31:0] v;
        int          nb;
        e  = ref_err(sz, a);
        v  = 32'h0;
        nb = nbytes(sz);
        if (!e && w) begin
            for (int i = 0; i < nb; i++) mem_m[d][a+i] = 8'(wd >> (8 * i));
        end else if (!e) begin
            for (int i = 0; i < nb; i++) v = v + (32'(mem_m[d][a+i]) << (8 * i));
            if (!u && nb < 4 && ((v >> (8 * nb - 1)) & 32'h1) != 0)
                v = v | (32'hFFFF_FFFF << (8 * nb));
        end
        return {8'((e || w) ? 1 : d), v, e, 1'b1};
    endfunction

    // Issue one op on DUT d from a negedge; returns {latency, data, err, clean-after}
    task automatic do_op(input int d, input logic w, input logic [1:0] sz, input logic u,
                         input logic [6:0] a, input logic [31:0] wd, output logic [41:0] got);
        int          lat;
        logic [31:0] rd;
        logic        er;
        logic        cl;
        int          k;
        lat = 0; rd = 32'h0; er = 1'b0; cl = 1'b0; k = 0;
        while (!ready[d] && k < 20) begin
            @(negedge clk);
            k++;
        end
        we[d] = w; size[d] = sz; uns[d] = u; addr[d] = a; din[d] = wd; req[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[d] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (valid[d]) begin
                lat = c; rd = dout[d]; er = aerr[d];
                break;
            end
            @(negedge clk);
        end
        if (lat > 0) begin
            @(negedge clk);
            cl = !valid[d] && dout[d] == 32'h0 && !aerr[d] && ready[d];
        end
        got = {8'(lat), rd, er, cl};
    endtask

    task automatic test_reset();
        for (int d = 1; d <= 4; d++) begin
            n_checks++;
            if ({ready[d], valid[d], dout[d], aerr[d]} !== {1'b1, 1'b0, 32'h0, 1'b0})
                $display("FAIL reset_state dut%0d got rdy/vld/dout/err=%b/%b/%h/%b exp=1/0/00000000/0",
                         d, ready[d], valid[d], dout[d], aerr[d]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [41:0] got, exp;
        int vcnt;
        do_op(3, 1, 2'd2, 0, 7'h00, 32'hDEAD_BEEF, got); exp = exp_op(3, 1, 2'd2, 0, 'h00, 32'hDEAD_BEEF);
        n_checks++;
        if (got !== exp) $display("FAIL rst_mid_store got=%h exp=%h", got, exp); else n_pass++;
        size[3] = 2'd2; we[3] = 1'b0; uns[3] = 1'b0; addr[3] = 7'h00; req[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[3] = 1'b0;
        n_checks++;
        if (ready[3] !== 1'b0) $display("FAIL rst_mid_busy got ready=%b exp=0", ready[3]); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({ready[3], valid[3], dout[3]} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL rst_mid_async got rdy/vld/dout=%b/%b/%h exp=1/0/00000000", ready[3], valid[3], dout[3]);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        ref_clear();
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid[3]) vcnt++;
            @(negedge clk);
        end
        n_checks++;
        if (vcnt !== 0) $display("FAIL rst_mid_novalid got %0d pulses exp=0", vcnt); else n_pass++;
        do_op(3, 0, 2'd2, 0, 7'h00, 32'h0, got);
        n_checks++;
        if (got !== {8'd3, 32'h0, 1'b0, 1'b1}) $display("FAIL rst_mid_cleared got=%h exp=%h", got, {8'd3, 32'h0, 1'b0, 1'b1});
        else n_pass++;
        void'(exp_op(3, 0, 2'd2, 0, 'h00, 32'h0));
    endtask

    task automatic test_word();
        logic [41:0] got;
        int ds [2] = '{1, 4};
        for (int j = 0; j < 2; j++) begin
            do_op(ds[j], 1, 2'd2, 0, 7'h10, 32'h8000_00F4, got);
            void'(exp_op(ds[j], 1, 2'd2, 0, 'h10, 32'h8000_00F4));
            n_checks++;
            if (got !== {8'd1, 32'h0, 1'b0, 1'b1}) $display("FAIL word_store dut%0d got=%h exp=%h", ds[j], got, {8'd1, 32'h0, 1'b0, 1'b1});
            else n_pass++;
            do_op(ds[j], 0, 2'd2, 0, 7'h10, 32'h0, got);
            n_checks++;
            if (got !== {8'(ds[j]), 32'h8000_00F4, 1'b0, 1'b1})
                $display("FAIL word_load dut%0d got=%h exp=%h", ds[j], got, {8'(ds[j]), 32'h8000_00F4, 1'b0, 1'b1});
            else n_pass++;
        end
    endtask

    task automatic test_byte_lanes();
        logic [41:0] got;
        logic [31:0] exp_d [4] = '{32'h11AA_3344, 32'hFFFF_FFAA, 32'h0000_00AA, 32'h0000_11AA};
        logic [1:0]  szs   [4] = '{2'd2, 2'd0, 2'd0, 2'd1};
        logic        us    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [6:0]  as    [4] = '{7'h20, 7'h22, 7'h22, 7'h22};
        do_op(2, 1, 2'd2, 0, 7'h20, 32'h1122_3344, got); void'(exp_op(2, 1, 2'd2, 0, 'h20, 32'h1122_3344));
        do_op(2, 1, 2'd0, 0, 7'h22, 32'h9876_54AA, got); void'(exp_op(2, 1, 2'd0, 0, 'h22, 32'h9876_54AA));
        n_checks++;
        if (got !== {8'd1, 32'h0, 1'b0, 1'b1}) $display("FAIL byte_store got=%h exp=%h", got, {8'd1, 32'h0, 1'b0, 1'b1});
        else n_pass++;
        for (int j = 0; j < 4; j++) begin
            do_op(2, 0, szs[j], us[j], as[j], 32'h0, got);
            n_checks++;
            if (got !== {8'd2, exp_d[j], 1'b0, 1'b1}) $display("FAIL byte_lane_%0d got=%h exp=%h", j, got, {8'd2, exp_d[j], 1'b0, 1'b1});
            else n_pass++;
        end
    endtask

    task automatic test_half_sign();
        logic [41:0] got;
        logic [31:0] exp_d [3] = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_1234};
        logic [1:0]  szs   [3] = '{2'd1, 2'd1, 2'd2};
        logic        us    [3] = '{1'b0, 1'b1, 1'b0};
        logic [6:0]  as    [3] = '{7'h06, 7'h06, 7'h04};
        do_op(4, 1, 2'd2, 0, 7'h04, 32'h5555_1234, got); void'(exp_op(4, 1, 2'd2, 0, 'h04, 32'h5555_1234));
        do_op(4, 1, 2'd1, 0, 7'h06, 32'hFFFF_8001, got); void'(exp_op(4, 1, 2'd1, 0, 'h06, 32'hFFFF_8001));
        for (int j = 0; j < 3; j++) begin
            do_op(4, 0, szs[j], us[j], as[j], 32'h0, got);
            n_checks++;
            if (got !== {8'd4, exp_d[j], 1'b0, 1'b1}) $display("FAIL half_%0d got=%h exp=%h", j, got, {8'd4, exp_d[j], 1'b0, 1'b1});
            else n_pass++;
        end
    endtask

    task automatic test_misalign();
        logic [41:0] got;
        int          ds  [5] = '{1, 1, 1, 1, 4};
        logic        ws  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  szs [5] = '{2'd2, 2'd1, 2'd3, 2'd3, 2'd2};
        logic [6:0]  as  [5] = '{7'h0A, 7'h03, 7'h08, 7'h08, 7'h09};
        do_op(1, 1, 2'd2, 0, 7'h08, 32'hA5A5_5A5A, got); void'(exp_op(1, 1, 2'd2, 0, 'h08, 32'hA5A5_5A5A));
        do_op(4, 1, 2'd2, 0, 7'h08, 32'hA5A5_5A5A, got); void'(exp_op(4, 1, 2'd2, 0, 'h08, 32'hA5A5_5A5A));
        for (int j = 0; j < 5; j++) begin
            do_op(ds[j], ws[j], szs[j], 0, as[j], 32'hFFFF_FFFF, got);
            n_checks++;
            if (got !== {8'd1, 32'h0, 1'b1, 1'b1}) $display("FAIL misalign_%0d got=%h exp=%h", j, got, {8'd1, 32'h0, 1'b1, 1'b1});
            else n_pass++;
        end
        do_op(1, 0, 2'd2, 0, 7'h08, 32'h0, got);
        n_checks++;
        if (got !== {8'd1, 32'hA5A5_5A5A, 1'b0, 1'b1}) $display("FAIL misalign_unchanged got=%h exp=%h", got, {8'd1, 32'hA5A5_5A5A, 1'b0, 1'b1});
        else n_pass++;
    endtask

    task automatic test_handshake();
        logic [41:0] got, exp;
        logic [31:0] val;
        logic [11:0] rdy_pat;
        int acc, vcnt, bad;
        val = $urandom;
        do_op(2, 1, 2'd2, 0, 7'h30, val, got); void'(exp_op(2, 1, 2'd2, 0, 'h30, val));
        we[2] = 1'b0; size[2] = 2'd2; uns[2] = 1'b0; addr[2] = 7'h30; req[2] = 1'b1;
        acc = 0; vcnt = 0; bad = 0; rdy_pat = '0;
        for (int i = 0; i < 16; i++) begin
            if (i == 12) req[2] = 1'b0;
            if (i < 12) rdy_pat[i] = ready[2];
            if (req[2] && ready[2]) acc++;
            if (valid[2]) begin
                vcnt++;
                if (dout[2] !== val) bad++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (rdy_pat !== 12'h249) $display("FAIL hs_ready_pattern got=%h exp=249", rdy_pat); else n_pass++;
        n_checks++;
        if ({acc, vcnt, bad} !== {32'd4, 32'd4, 32'd0}) $display("FAIL hs_counts got acc/vld/bad=%0d/%0d/%0d exp=4/4/0", acc, vcnt, bad);
        else n_pass++;
        req[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        we[2] = 1'b1; din[2] = ~val;
        @(posedge clk);
        @(negedge clk);
        req[2] = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid[2]) vcnt++;
            @(negedge clk);
        end
        n_checks++;
        if (vcnt !== 1) $display("FAIL hs_ignored_req got %0d pulses exp=1", vcnt); else n_pass++;
        do_op(2, 0, 2'd2, 0, 7'h30, 32'h0, got); exp = exp_op(2, 0, 2'd2, 0, 'h30, 32'h0);
        n_checks++;
        if (got !== exp) $display("FAIL hs_no_write got=%h exp=%h", got, exp); else n_pass++;
    endtask

    task automatic test_random();
        logic [41:0] got, exp;
        logic [1:0]  sz;
        logic [6:0]  a;
        logic        w, u;
        logic [31:0] wd;
        for (int d = 1; d <= 4; d++) begin
            for (int i = 0; i < 30; i++) begin
                sz = 2'($urandom_range(0, 3));
                a  = 7'($urandom_range(0, 127));
                if ($urandom_range(0, 3) != 0) a = (sz == 2'd1) ? (a & 7'h7E) : (sz == 2'd2) ? (a & 7'h7C) : a;
                w  = ($urandom_range(0, 2) == 0);
                u  = 1'($urandom_range(0, 1));
                wd = $urandom;
                do_op(d, w, sz, u, a, wd, got);
                exp = exp_op(d, w, sz, u, int'(a), wd);
                n_checks++;
                if (got !== exp) $display("FAIL rand dut%0d op%0d we=%b sz=%0d a=%h got=%h exp=%h", d, i, w, sz, a, got, exp);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; size[d] = 2'd0; uns[d] = 1'b0; addr[d] = '0; din[d] = '0;
        end
        ref_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_reset_mid();
        test_word();
        test_byte_lanes();
        test_half_sign();
        test_misalign();
        test_handshake();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
